// File: rtl/two_ch_splitter.sv
// Two-channel frame splitter: routes merged 64-bit frames to CH0/CH1 by header
// channel ID, synthesizing lost footers and dropping headerless data.
module two_ch_splitter #(
    parameter int unsigned               DATA_WIDTH   = 64,
    parameter int unsigned               CNT_WIDTH    = 16,
    parameter logic [DATA_WIDTH-1:0]     SYNTH_FOOTER = 64'h0000_0000_0000_5555
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic [DATA_WIDTH-1:0] DIN,
    input  logic                  iVALID,
    output logic                  oREADY,
    output logic [DATA_WIDTH-1:0] CH0_DOUT,
    output logic                  CH0_oVALID,
    input  logic                  CH0_iREADY,
    output logic [DATA_WIDTH-1:0] CH1_DOUT,
    output logic                  CH1_oVALID,
    input  logic                  CH1_iREADY,
    output logic [CNT_WIDTH-1:0]  HDR_LOST_CNT,
    output logic [CNT_WIDTH-1:0]  FTR_LOST_CNT,
    output logic [CNT_WIDTH-1:0]  BAD_CH_CNT,
    output logic                  BUSY
);

    localparam logic [15:0]          HDR_TAG = 16'hAAAA;
    localparam logic [15:0]          FTR_TAG = 16'h5555;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUTE = 2'd1,
        PEND  = 2'd2,
        DROP  = 2'd3
    } state_t;

    state_t                state, state_nxt;
    logic                  cur_ch, cur_ch_nxt;
    logic [DATA_WIDTH-1:0] pend_hdr, pend_nxt;

    logic                  is_hdr, is_ftr, din_ok, din_ch, pend_ok, pend_ch;
    logic [1:0]            free;
    logic [1:0]            wr;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  inc_hdr, inc_ftr, inc_bad;

    // Field decode of the incoming word and of the parked header
    always_comb begin
        is_hdr  = (DIN[63:48] == HDR_TAG);
        is_ftr  = (DIN[15:0] == FTR_TAG) && !is_hdr;
        din_ok  = (DIN[47:45] == 3'b000);
        din_ch  = DIN[44];
        pend_ok = (pend_hdr[47:45] == 3'b000);
        pend_ch = pend_hdr[44];
        free[0] = !CH0_oVALID || CH0_iREADY;
        free[1] = !CH1_oVALID || CH1_iREADY;
    end

    // Next-state, slot write and ready decode
    always_comb begin
        state_nxt  = state;
        cur_ch_nxt = cur_ch;
        pend_nxt   = pend_hdr;
        wr         = 2'b00;
        wdata      = DIN;
        inc_hdr    = 1'b0;
        inc_ftr    = 1'b0;
        inc_bad    = 1'b0;
        oREADY     = 1'b0;
        case (state)
            IDLE, DROP: begin
                oREADY = 1'b1;
                if (is_hdr && din_ok) begin
                    // Hold a good header until its target slot can take it
                    oREADY = free[din_ch];
                    if (iVALID && free[din_ch]) begin
                        wr[din_ch] = 1'b1;
                        cur_ch_nxt = din_ch;
                        state_nxt  = ROUTE;
                    end
                end else if (iVALID) begin
                    if (is_hdr) begin
                        inc_bad   = 1'b1;
                        state_nxt = DROP;
                    end else if (state == IDLE) begin
                        inc_hdr = 1'b1;
                    end else if (is_ftr) begin
                        state_nxt = IDLE;
                    end
                end
            end
            ROUTE: begin
                oREADY = free[cur_ch];
                if (iVALID && free[cur_ch]) begin
                    wr[cur_ch] = 1'b1;
                    if (is_hdr) begin
                        wdata     = SYNTH_FOOTER;
                        inc_ftr   = 1'b1;
                        pend_nxt  = DIN;
                        state_nxt = PEND;
                    end else if (is_ftr) begin
                        state_nxt = IDLE;
                    end
                end
            end
            PEND: begin
                if (pend_ok) begin
                    if (free[pend_ch]) begin
                        wr[pend_ch] = 1'b1;
                        wdata       = pend_hdr;
                        cur_ch_nxt  = pend_ch;
                        state_nxt   = ROUTE;
                    end
                end else begin
                    inc_bad   = 1'b1;
                    state_nxt = DROP;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state        <= IDLE;
            cur_ch       <= 1'b0;
            pend_hdr     <= '0;
            CH0_DOUT     <= '0;
            CH0_oVALID   <= 1'b0;
            CH1_DOUT     <= '0;
            CH1_oVALID   <= 1'b0;
            HDR_LOST_CNT <= '0;
            FTR_LOST_CNT <= '0;
            BAD_CH_CNT   <= '0;
            BUSY         <= 1'b0;
        end else begin
            state      <= state_nxt;
            cur_ch     <= cur_ch_nxt;
            pend_hdr   <= pend_nxt;
            BUSY       <= (state_nxt != IDLE);
            // A write replaces a consumed word in the same cycle, so no bubble
            CH0_oVALID <= wr[0] || (CH0_oVALID && !CH0_iREADY);
            CH1_oVALID <= wr[1] || (CH1_oVALID && !CH1_iREADY);
            if (wr[0]) CH0_DOUT <= wdata;
            if (wr[1]) CH1_DOUT <= wdata;
            if (inc_hdr && HDR_LOST_CNT != CNT_MAX) HDR_LOST_CNT <= HDR_LOST_CNT + CNT_WIDTH'(1);
            if (inc_ftr && FTR_LOST_CNT != CNT_MAX) FTR_LOST_CNT <= FTR_LOST_CNT + CNT_WIDTH'(1);
            if (inc_bad && BAD_CH_CNT != CNT_MAX)   BAD_CH_CNT   <= BAD_CH_CNT + CNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_two_ch_splitter.sv
// Randomized self-checking bench for two_ch_splitter against a frame-level
// reference model of routing, footer repair and fault counting.
module tb_two_ch_splitter;

    localparam logic [63:0] SYNTH = 64'h0000_0000_0000_5555;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic [63:0] DIN = '0;
    logic        iVALID = 1'b0;
    logic        oREADY;
    logic [63:0] CH0_DOUT, CH1_DOUT;
    logic        CH0_oVALID, CH1_oVALID;
    logic        CH0_iREADY = 1'b1;
    logic        CH1_iREADY = 1'b1;
    logic [15:0] HDR_LOST_CNT, FTR_LOST_CNT, BAD_CH_CNT;
    logic        BUSY;

    two_ch_splitter dut (
        .CLK(CLK), .RESET(RESET), .DIN(DIN), .iVALID(iVALID), .oREADY(oREADY),
        .CH0_DOUT(CH0_DOUT), .CH0_oVALID(CH0_oVALID), .CH0_iREADY(CH0_iREADY),
        .CH1_DOUT(CH1_DOUT), .CH1_oVALID(CH1_oVALID), .CH1_iREADY(CH1_iREADY),
        .HDR_LOST_CNT(HDR_LOST_CNT), .FTR_LOST_CNT(FTR_LOST_CNT),
        .BAD_CH_CNT(BAD_CH_CNT), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    int vectors = 0;
    int errors  = 0;

    // Reference model state: expected per-channel words and their accept cycles
    logic [63:0] q0[$], q1[$];
    int          c0[$], c1[$];
    int          mode = 0;      // 0 between frames, 1 inside a frame, 2 discarding
    int          cur  = 0;
    int          m_hdr = 0, m_ftr = 0, m_bad = 0;
    int          cyc = 0;
    bit          lat_en = 1'b0;
    int          ch1_seen = 0, vcnt = 0, rdy_low = 0, w0_cnt = 0;
    bit          rr_en = 1'b0;
    logic        r0_val = 1'b1, r1_val = 1'b1;
    bit          st0 = 1'b0, st1 = 1'b0;
    logic [63:0] pd0 = '0, pd1 = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic push(input int ch, input logic [63:0] w);
        if (ch == 0) begin q0.push_back(w); c0.push_back(cyc); end
        else         begin q1.push_back(w); c1.push_back(cyc); end
    endtask

    task automatic model_in(input logic [63:0] w);
        bit h, f;
        int ch;
        h  = (w[63:48] == 16'hAAAA);
        f  = (w[15:0] == 16'h5555) && !h;
        ch = int'(w[47:44]);
        if (h) begin
            if (mode == 1) begin push(cur, SYNTH); m_ftr++; end
            if (ch < 2) begin push(ch, w); cur = ch; mode = 1; end
            else begin m_bad++; mode = 2; end
        end else if (mode == 1) begin
            push(cur, w);
            if (f) mode = 0;
        end else if (mode == 0) begin
            m_hdr++;
        end else if (f) begin
            mode = 0;
        end
    endtask

    // Consumer ready generation (random or directed)
    always @(posedge CLK) begin
        if (rr_en) begin
            CH0_iREADY <= ($urandom_range(0, 3) != 0);
            CH1_iREADY <= ($urandom_range(0, 3) != 0);
        end else begin
            CH0_iREADY <= r0_val;
            CH1_iREADY <= r1_val;
        end
    end

    // Monitor: sample mid-cycle, check holds and outputs, feed accepted words to the model
    always @(negedge CLK) begin
        logic [63:0] e;
        int          c;
        cyc++;
        if (RESET) begin
            st0 = 1'b0;
            st1 = 1'b0;
        end else begin
            if (st0) begin chk("ch0_hold_v", 64'(CH0_oVALID), 1); chk("ch0_hold_d", CH0_DOUT, pd0); end
            if (st1) begin chk("ch1_hold_v", 64'(CH1_oVALID), 1); chk("ch1_hold_d", CH1_DOUT, pd1); end
            st0 = CH0_oVALID && !CH0_iREADY; pd0 = CH0_DOUT;
            st1 = CH1_oVALID && !CH1_iREADY; pd1 = CH1_DOUT;
            if (CH1_oVALID) ch1_seen++;
            if (CH0_oVALID || CH1_oVALID) vcnt++;
            if (iVALID && !oREADY) rdy_low++;
            if (CH0_oVALID && CH0_iREADY) begin
                if (q0.size() == 0) chk("ch0_unexpected", CH0_DOUT, ~CH0_DOUT);
                else begin
                    e = q0.pop_front(); c = c0.pop_front();
                    chk("ch0_data", CH0_DOUT, e);
                    if (lat_en) chk("ch0_latency", 64'(cyc - c), 1);
                    w0_cnt++;
                end
            end
            if (CH1_oVALID && CH1_iREADY) begin
                if (q1.size() == 0) chk("ch1_unexpected", CH1_DOUT, ~CH1_DOUT);
                else begin
                    e = q1.pop_front(); c = c1.pop_front();
                    chk("ch1_data", CH1_DOUT, e);
                end
            end
            if (iVALID && oREADY) model_in(DIN);
        end
    end

    function automatic logic [63:0] samp();
        logic [63:0] w;
        logic [11:0] s;
        for (int i = 0; i < 4; i++) begin
            s = 12'($urandom);
            w[16*i +: 16] = {{4{s[11]}}, s};
        end
        return w;
    endfunction

    function automatic logic [63:0] hdr_w(input int ch, input int len);
        return {16'hAAAA, 4'(ch), 32'($urandom), 12'(len)};
    endfunction

    function automatic logic [63:0] ftr_w();
        logic [63:0] w;
        w = samp();
        w[15:0] = 16'h5555;
        return w;
    endfunction

    task automatic send(input logic [63:0] w);
        int n;
        n = 0;
        DIN = w;
        iVALID = 1'b1;
        @(negedge CLK);
        while (!oREADY && n < 1000) begin @(negedge CLK); n++; end
        if (n >= 1000) chk("send_timeout", 64'(n), 0);
        @(posedge CLK);
        #1;
        iVALID = 1'b0;
    endtask

    task automatic send_frame(input int ch, input int n, input bit with_ftr);
        send(hdr_w(ch, n));
        for (int i = 0; i < n; i++) send(samp());
        if (with_ftr) send(ftr_w());
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q0.size() != 0 || q1.size() != 0) && n < 2000) begin @(posedge CLK); n++; end
        if (n >= 2000) chk("drain_timeout", 64'(q0.size() + q1.size()), 0);
        repeat (3) @(posedge CLK);
        #1;
    endtask

    task automatic check_counts(input string t);
        chk({t, "_hdr_lost"}, 64'(HDR_LOST_CNT), 64'(m_hdr));
        chk({t, "_ftr_lost"}, 64'(FTR_LOST_CNT), 64'(m_ftr));
        chk({t, "_bad_ch"},   64'(BAD_CH_CNT),   64'(m_bad));
        chk({t, "_busy"},     64'(BUSY),         64'(mode != 0));
    endtask

    initial begin
        int r;
        repeat (3) @(posedge CLK);
        #1;
        RESET = 1'b0;
        #1;
        chk("rst_v0", 64'(CH0_oVALID), 0);
        chk("rst_v1", 64'(CH1_oVALID), 0);
        chk("rst_d0", CH0_DOUT, 0);
        chk("rst_d1", CH1_DOUT, 0);
        chk("rst_rdy", 64'(oREADY), 1);
        check_counts("rst");

        // Basic routing with 1-cycle latency check
        lat_en = 1'b1; ch1_seen = 0; w0_cnt = 0;
        send(hdr_w(0, 200));
        for (int i = 0; i < 200; i++) send(64'hFFFF_FFFF_FFFF_FFFF);
        send(ftr_w());
        drain();
        lat_en = 1'b0;
        chk("t1_words", 64'(w0_cnt), 202);
        chk("t1_ch1_quiet", 64'(ch1_seen), 0);
        check_counts("t1");

        // Back-to-back frames on alternating channels
        rdy_low = 0;
        send_frame(1, 8, 1);
        send_frame(0, 8, 1);
        drain();
        chk("t2_ready_high", 64'(rdy_low), 0);
        check_counts("t2");

        // Lost footer
        rdy_low = 0;
        send_frame(1, 10, 0);
        send_frame(0, 3, 1);
        drain();
        chk("t3_pend_stall", 64'(rdy_low >= 1), 1);
        chk("t3_ftr_lost_abs", 64'(FTR_LOST_CNT), 1);
        check_counts("t3");

        // Headerless words
        vcnt = 0;
        for (int i = 0; i < 5; i++) send(samp());
        send(ftr_w());
        drain();
        chk("t4_no_out", 64'(vcnt), 0);
        chk("t4_hdr_lost_abs", 64'(HDR_LOST_CNT), 6);
        check_counts("t4");

        // Bad channel, then a normal frame
        vcnt = 0;
        send_frame(3, 4, 1);
        drain();
        chk("t5_no_out", 64'(vcnt), 0);
        chk("t5_bad_abs", 64'(BAD_CH_CNT), 1);
        send_frame(0, 5, 1);
        drain();
        check_counts("t5");

        // CH0 back-pressure 1-0-0-1 mid-frame
        fork
            send_frame(0, 20, 1);
            begin
                repeat (8) @(posedge CLK);
                r0_val = 1'b0;
                repeat (2) @(posedge CLK);
                r0_val = 1'b1;
            end
        join
        drain();
        check_counts("t6");

        // Reset mid-frame
        send_frame(0, 5, 0);
        RESET = 1'b1;
        @(posedge CLK);
        #1;
        RESET = 1'b0;
        q0.delete(); q1.delete(); c0.delete(); c1.delete();
        mode = 0; m_hdr = 0; m_ftr = 0; m_bad = 0;
        chk("t7_v0", 64'(CH0_oVALID), 0);
        chk("t7_v1", 64'(CH1_oVALID), 0);
        check_counts("t7");
        send_frame(1, 4, 1);
        drain();
        check_counts("t7b");

        // Randomized traffic with random consumer back-pressure
        rr_en = 1'b1;
        for (int k = 0; k < 60; k++) begin
            r = $urandom_range(0, 9);
            if (r == 0) begin
                for (int i = 0; i < $urandom_range(1, 3); i++) send(samp());
            end else if (r == 1) begin
                send_frame($urandom_range(2, 15), $urandom_range(0, 4), $urandom_range(0, 1) == 1);
            end else if (r == 2) begin
                send_frame($urandom_range(0, 1), $urandom_range(0, 6), 0);
            end else begin
                send_frame($urandom_range(0, 1), $urandom_range(0, 12), 1);
            end
        end
        send_frame(0, 2, 1);
        rr_en = 1'b0;
        drain();
        check_counts("rand");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/two_ch_splitter.md
Name: two_ch_splitter

Overview:
- Inverse of the two-channel mixer: takes the merged 64-bit frame stream and routes each frame to a per-channel output (CH0/CH1) by the channel ID in its header.
- Sits between the readout link receiver and the per-channel consumers.
- Repairs framing:
  - A frame whose footer is missing gets a synthesized footer.
  - Words arriving without a header are dropped.
  - Each fault is counted.
- Frame format:
  - Header: DIN[63:48]=16'hAAAA, DIN[47:44]=channel ID, DIN[43:12]=time[31:0], DIN[11:0]=frame length.
  - Footer: DIN[15:0]=16'h5555.
  - Body: signed 12-bit samples sign-extended to 16 bits. The upper nibble of every body sample is therefore 0x0 or 0xF, so 0xAAAA and 0x5555 can never occur in a body word.

Parameters:
- DATA_WIDTH, 64, stream word width; fixed field positions above assume 64.
- CNT_WIDTH, 16, width of each saturating error counter.
- SYNTH_FOOTER, 64'h0000_0000_0000_5555, word emitted when a footer is lost.

Ports:
- CLK  in  1  clock
- RESET  in  1  synchronous, active-high reset
- DIN  in  DATA_WIDTH  merged stream data
- iVALID  in  1  DIN valid
- oREADY  out  1  splitter accepts DIN this cycle
- CH0_DOUT  out  DATA_WIDTH  channel-0 frame stream
- CH0_oVALID  out  1  CH0_DOUT valid
- CH0_iREADY  in  1  channel-0 consumer ready
- CH1_DOUT  out  DATA_WIDTH  channel-1 frame stream
- CH1_oVALID  out  1  CH1_DOUT valid
- CH1_iREADY  in  1  channel-1 consumer ready
- HDR_LOST_CNT  out  CNT_WIDTH  count of words dropped in IDLE (headerless data)
- FTR_LOST_CNT  out  CNT_WIDTH  count of synthesized footers
- BAD_CH_CNT  out  CNT_WIDTH  count of frames with channel ID not in {0,1}
- BUSY  out  1  state != IDLE

Behaviour:
- Reset (synchronous, RESET=1 at a CLK edge):
  - State=IDLE.
  - CHx_oVALID=0, CHx_DOUT=0.
  - All counters=0, pending-header register cleared.
  - Reset mid-frame discards the frame and any pending header without a footer.
- Output slots and handshake:
  - Each channel has one registered output slot. Slot x is "free" when !CHx_oVALID || CHx_iREADY.
  - Writing a slot sets CHx_oVALID the next cycle. A consumed slot with no new write clears CHx_oVALID.
  - Latency: accepted word appears on CHx_DOUT 1 cycle after acceptance.
  - CHx_DOUT holds while CHx_oVALID && !CHx_iREADY.
  - Input accepted iff iVALID && oREADY.
- Definitions: hdr = DIN[63:48]==16'hAAAA; ftr = DIN[15:0]==16'h5555 && !hdr.
- IDLE (oREADY=1):
  - hdr with ch ID 0/1 and target slot free: write header to slot, latch cur_ch, go ROUTE.
  - hdr with ch ID 0/1 and target slot busy: oREADY is 0 for that cycle. oREADY is combinational on DIN[47:44] in IDLE only.
  - hdr with other ch ID: BAD_CH_CNT++, go DROP.
  - Non-hdr word: dropped, HDR_LOST_CNT++, stay IDLE.
- ROUTE (oREADY = slot[cur_ch] free):
  - Body word: written to slot[cur_ch].
  - ftr: written, go IDLE.
  - hdr (footer lost): write SYNTH_FOOTER to slot[cur_ch], FTR_LOST_CNT++, latch DIN into pending register, go PEND.
- PEND (oREADY=0):
  - Pending header is processed exactly as the IDLE hdr case, without counting it as a new input word.
  - Ch ID 0/1: waits for its slot to be free, writes the header, sets cur_ch, goes ROUTE.
  - Bad ID: BAD_CH_CNT++, go DROP.
- DROP (oREADY=1):
  - Words discarded. ftr → IDLE.
  - hdr → treated as in IDLE (no FTR_LOST count).
- Channels are independent: while ROUTE targets CH0, CH1 may still drain its slot.
- Back-pressure on the non-target channel never stalls input.
- Counters saturate at all-ones and never wrap.
- Simultaneous slot consume and write in the same cycle: the slot holds the new word with oVALID=1, no bubble. Full throughput is 1 word/cycle per frame.
- Frame length field is passed through, not checked.

Test Plan:
- Basic routing: CH0 frame {hdr ch=0, len=200, 200 samples 0xFFFF, ftr} with CH0_iREADY=1.
  - CH0 emits all 202 words, each 1 cycle after acceptance, identical to input.
  - CH1_oVALID stays 0; counters stay 0.
- Back-to-back routing: ch1 frame followed immediately by ch0 frame.
  - Each frame appears only on its channel; oREADY stays 1 throughout.
- Footer lost: hdr ch=1, 10 samples, then hdr ch=0 with no footer.
  - CH1 receives 11 words plus SYNTH_FOOTER.
  - FTR_LOST_CNT=1; oREADY=0 for ≥1 cycle (PEND).
  - CH0 header emitted afterwards.
- Header lost: 5 sample words, then ftr 0x...5555 while IDLE.
  - No CHx_oVALID; HDR_LOST_CNT=6; state stays IDLE.
- Bad channel: hdr ch=0x3, 4 samples, ftr.
  - BAD_CH_CNT=1; nothing emitted; next valid ch0 frame routes normally.
- Back-pressure and reset:
  - CH0_iREADY toggled 1-0-0-1 mid-frame: CH0_DOUT stable while stalled; no words lost or duplicated.
  - RESET=1 for one cycle mid-frame: next cycle all valids 0, counters 0, BUSY 0.
